mem_responder: RTL and testbench

- Memory-side responder for the multicycle CPU's unified instruction/data memory port.
- The CPU controller initiates reads and writes using the memory read/write strobes and an address, and holds them until this block returns ready.
- The block adds configurable wait states and reports an error on illegal requests, so the controller can stall or trap.
- It sits between the CPU datapath memory interface and the word storage array.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_array.sv | 28 ++
 rtl/mem_responder.sv | 138 +++++++++++++
 tb/tb_mem_responder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding, default sizes
// and the request legality helper used at acceptance time.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEFAULT_DATA_W     = 32;
  localparam int DEFAULT_DEPTH_LOG2 = 8;

  // Byte-offset bits that must be zero for a word-aligned address.
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'h0000_0003;

  // A request is illegal when both strobes are high, the address is not
  // word aligned, or any address bit above the storage range is set.
  // Out-of-range addresses are flagged rather than wrapped.
  function automatic logic req_illegal(
    input logic        rd,
    input logic        wr,
    input logic [31:0] addr,
    input int          depth_log2
  );
    logic both;
    logic misaligned;
    logic out_of_range;
    both         = rd & wr;
    misaligned   = ((addr & ADDR_ALIGN_MASK) != 32'd0);
    out_of_range = ((addr >> (depth_log2 + 2)) != 32'd0);
    return both | misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, combinational read.
// Contents are deliberately not reset.
module mem_array #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Commit a write word on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle CPU memory port. Accepts a held
// read/write strobe in IDLE, inserts WAIT_CYCLES wait states, then pulses
// ready (with err for illegal requests) for one cycle in RESP.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int DEPTH_LOG2  = DEFAULT_DEPTH_LOG2,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    wr_q;
  logic                    illegal_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    ready_q;
  logic                    err_q;

  logic                    req_d;
  logic                    illegal_d;
  logic [DEPTH_LOG2-1:0]   idx_d;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic [DATA_W-1:0]       arr_rdata;
  logic                    arr_we;

  // Decode the incoming request; only consumed while IDLE.
  always_comb begin
    req_d     = mem_read | mem_write;
    illegal_d = req_illegal(mem_read, mem_write, addr, DEPTH_LOG2);
    idx_d     = addr[DEPTH_LOG2+1:2];
  end

  // In IDLE the read port looks at the live address so that a zero-wait
  // read can load rdata on its acceptance edge; otherwise the latched index.
  always_comb begin
    rd_idx = idx_q;
    if (state_q == IDLE) begin
      rd_idx = idx_d;
    end
  end

  // A legal write commits at the end of RESP; an aborted request never
  // reaches RESP, so reset during WAIT cannot corrupt storage.
  assign arr_we = (state_q == RESP) && wr_q && !illegal_q;

  mem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (rd_idx),
    .rdata_o (arr_rdata)
  );

  // Request FSM with registered ready/err/rdata outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      illegal_q <= 1'b0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          if (req_d) begin
            idx_q     <= idx_d;
            wdata_q   <= wdata;
            wr_q      <= mem_write;
            illegal_q <= illegal_d;
            if (WAIT_CYCLES == 0) begin
              state_q <= RESP;
              ready_q <= 1'b1;
              err_q   <= illegal_d;
              if (!mem_write && !illegal_d) begin
                rdata_q <= arr_rdata;
              end
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            err_q   <= illegal_q;
            if (!wr_q && !illegal_q) begin
              rdata_q <= arr_rdata;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and
// one with none, sharing clock and reset.
module tb_mem_responder;

  logic        clk;
  logic        rst;

  logic        r2, w2;
  logic [31:0] a2, wd2;
  logic [31:0] rdata2;
  logic        ready2, err2;

  logic        r0, w0;
  logic [31:0] a0, wd0;
  logic [31:0] rdata0;
  logic        ready0, err0;

  int n_checks = 0;
  int n_errors = 0;

  mem_responder #(.DATA_W(32), .DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .mem_read(r2), .mem_write(w2), .addr(a2),
    .wdata(wd2), .rdata(rdata2), .ready(ready2), .err(err2)
  );

  mem_responder #(.DATA_W(32), .DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_read(r0), .mem_write(w0), .addr(a0),
    .wdata(wd0), .rdata(rdata0), .ready(ready0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit s0, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd);
    if (s0) begin
      r0 = rd; w0 = wr; a0 = a; wd0 = wd;
    end else begin
      r2 = rd; w2 = wr; a2 = a; wd2 = wd;
    end
  endtask

  // Issue one request, optionally changing addr/wdata one cycle after
  // acceptance, and wait for ready. lat counts cycles from acceptance to
  // ready; -1 if ready never came.
  task automatic xact(input bit s0, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] wd,
                      input bit chg, input logic [31:0] ca, input logic [31:0] cwd,
                      output int lat, output logic e, output logic [31:0] d);
    bit found;
    @(negedge clk);
    drive(s0, rd, wr, a, wd);
    lat = 0; e = 1'b0; d = '0; found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (s0 ? ready0 : ready2) begin
        e = s0 ? err0 : err2;
        d = s0 ? rdata0 : rdata2;
        found = 1'b1;
        break;
      end
      if (chg && lat == 1) drive(s0, rd, wr, ca, cwd);
    end
    drive(s0, 1'b0, 1'b0, 32'h0, 32'h0);
    if (!found) lat = -1;
  endtask

  int          lat;
  logic        e;
  logic [31:0] d;
  int          pulses;

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // 1. reset then idle
    repeat (3) begin
      @(negedge clk);
      check("rst_ready2", ready2, 0); check("rst_err2", err2, 0); check("rst_rdata2", rdata2, 0);
      check("rst_ready0", ready0, 0); check("rst_rdata0", rdata0, 0);
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready2", ready2, 0); check("idle_err2", err2, 0); check("idle_rdata2", rdata2, 0);
      check("idle_ready0", ready0, 0); check("idle_err0", err0, 0);
    end

    // 2. write then read, two wait states
    xact(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 0, 0, lat, e, d);
    check("wr10_lat", lat, 3); check("wr10_err", e, 0); check("wr10_rdata", d, 0);
    xact(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 0, 0, lat, e, d);
    check("rd10_lat", lat, 3); check("rd10_err", e, 0); check("rd10_data", d, 32'hDEADBEEF);
    @(negedge clk);
    check("rd10_ready_once", ready2, 0); check("rd10_err_low", err2, 0);
    check("rd10_hold", rdata2, 32'hDEADBEEF);

    // 3. zero wait states, back-to-back, last word
    xact(1'b1, 1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, 1'b0, 0, 0, lat, e, d);
    check("z_wr3fc_lat", lat, 1); check("z_wr3fc_err", e, 0);
    xact(1'b1, 1'b0, 1'b1, 32'h0, 32'h11111111, 1'b0, 0, 0, lat, e, d);
    check("z_wr0_lat", lat, 1);
    xact(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0, lat, e, d);
    check("z_rd0_lat", lat, 1); check("z_rd0_data", d, 32'h11111111); check("z_rd0_err", e, 0);
    xact(1'b1, 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0, 0, 0, lat, e, d);
    check("z_rd3fc_lat", lat, 1); check("z_rd3fc_data", d, 32'hCAFEF00D); check("z_rd3fc_err", e, 0);
    xact(1'b1, 1'b1, 1'b0, 32'h2, 32'h0, 1'b0, 0, 0, lat, e, d);
    check("z_mis_err", e, 1); check("z_mis_rdata", d, 32'hCAFEF00D);

    // 4. illegal requests
    xact(1'b0, 1'b0, 1'b1, 32'h0, 32'h0A0A0A0A, 1'b0, 0, 0, lat, e, d);
    check("wr0_err", e, 0);
    xact(1'b0, 1'b1, 1'b0, 32'h12, 32'h0, 1'b0, 0, 0, lat, e, d);
    check("mis_lat", lat, 3); check("mis_err", e, 1); check("mis_rdata", d, 32'hDEADBEEF);
    @(negedge clk);
    check("mis_err_after", err2, 0);
    xact(1'b0, 1'b0, 1'b1, 32'h400, 32'hBAD0BAD0, 1'b0, 0, 0, lat, e, d);
    check("oor_lat", lat, 3); check("oor_err", e, 1);
    xact(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0, lat, e, d);
    check("oor_rd0_err", e, 0); check("oor_rd0_data", d, 32'h0A0A0A0A);
    xact(1'b0, 1'b1, 1'b0, 32'h80000000, 32'h0, 1'b0, 0, 0, lat, e, d);
    check("hi_err", e, 1); check("hi_rdata", d, 32'h0A0A0A0A);
    xact(1'b0, 1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 1'b0, 0, 0, lat, e, d);
    check("both_err", e, 1); check("both_rdata", d, 32'h0A0A0A0A);
    xact(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0, lat, e, d);
    check("both_nowrite", d, 32'h0A0A0A0A);
    xact(1'b0, 1'b0, 1'b1, 32'h3FC, 32'h77777777, 1'b0, 0, 0, lat, e, d);
    check("last_wr_err", e, 0);
    xact(1'b0, 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0, 0, 0, lat, e, d);
    check("last_rd_err", e, 0); check("last_rd_data", d, 32'h77777777);

    // 5. reset during WAIT aborts the write
    xact(1'b0, 1'b0, 1'b1, 32'h20, 32'h55AA55AA, 1'b0, 0, 0, lat, e, d);
    check("pre20_err", e, 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    pulses = 0;
    repeat (2) begin @(negedge clk); if (ready2) pulses++; end
    check("rstmid_rdata", rdata2, 0);
    rst = 1'b1;
    repeat (4) begin @(negedge clk); if (ready2) pulses++; end
    check("rstmid_no_ready", pulses, 0);
    xact(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 0, 0, lat, e, d);
    check("rstmid_rd_lat", lat, 3); check("rstmid_rd_data", d, 32'h55AA55AA);

    // 6. input changes during WAIT are ignored
    xact(1'b0, 1'b0, 1'b1, 32'h34, 32'h34343434, 1'b0, 0, 0, lat, e, d);
    xact(1'b0, 1'b0, 1'b1, 32'h30, 32'h0BADCAFE, 1'b1, 32'h34, 32'hFFFFFFFF, lat, e, d);
    check("chg_wr_lat", lat, 3); check("chg_wr_err", e, 0);
    xact(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 32'h10, 32'h0, lat, e, d);
    check("chg_rd30", d, 32'h0BADCAFE);
    xact(1'b0, 1'b1, 1'b0, 32'h34, 32'h0, 1'b0, 0, 0, lat, e, d);
    check("chg_rd34", d, 32'h34343434);
    xact(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 32'h13, 32'h0, lat, e, d);
    check("chg_mis_ignored_err", e, 0); check("chg_mis_ignored_data", d, 32'h0BADCAFE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
